// File: rtl/alu_pkg.sv
// Opcode encoding for the calculator ALU, shared with the keypad decoder.
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
endpackage

// File: rtl/alu_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, done pulses once.
module alu_divider #(
    parameter int inSize = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [inSize-1:0] dividend,
    input  logic [inSize-1:0] divisor,
    output logic [inSize-1:0] quotient,
    output logic [inSize-1:0] remainder,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(inSize + 1);

    logic [inSize-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [inSize:0]   shifted;

    // A zero divisor always "fits", so the quotient fills with ones and the
    // dividend bits shift straight into the remainder.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[inSize-1]};
        if (start && !busy_q) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(inSize);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = shifted[inSize-1:0] - dvs_q;
                quo_d = {quo_q[inSize-2:0], 1'b1};
            end else begin
                rem_d = shifted[inSize-1:0];
                quo_d = {quo_q[inSize-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: rtl/alu.sv
// Registered calculator ALU: operand stage, combinational add/sub/mul, iterative divide.
module alu
    import alu_pkg::*;
#(
    parameter int inSize = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          operation,
    input  logic [inSize-1:0]   A,
    input  logic [inSize-1:0]   B,
    output logic [2*inSize-1:0] result,
    output logic                valid
);
    localparam int RW = 2 * inSize;

    logic              stg_vld_q, stg_vld_d;
    logic [1:0]        stg_op_q, stg_op_d;
    logic [inSize-1:0] stg_a_q, stg_a_d, stg_b_q, stg_b_d;
    logic [RW-1:0]     result_q, result_d;
    logic              valid_q, valid_d;

    logic              accept, div_busy, div_done;
    logic [inSize-1:0] div_quo, div_rem;
    logic [RW-1:0]     a_ext, b_ext, alu_res;

    assign accept = en && !div_busy;

    alu_divider #(.inSize(inSize)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && operation == OP_DIV),
        .dividend  (A),
        .divisor   (B),
        .quotient  (div_quo),
        .remainder (div_rem),
        .busy      (div_busy),
        .done      (div_done)
    );

    // Widening to RW before the arithmetic gives the carry, the sign
    // extension of a negative difference and the full product for free.
    always_comb begin
        stg_vld_d = accept && operation != OP_DIV;
        stg_op_d  = stg_op_q;
        stg_a_d   = stg_a_q;
        stg_b_d   = stg_b_q;
        if (accept) begin
            stg_op_d = operation;
            stg_a_d  = A;
            stg_b_d  = B;
        end
        a_ext   = {{inSize{1'b0}}, stg_a_q};
        b_ext   = {{inSize{1'b0}}, stg_b_q};
        alu_res = '0;
        case (stg_op_q)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_MUL:  alu_res = a_ext * b_ext;
            default: alu_res = '0;
        endcase
        result_d = result_q;
        valid_d  = 1'b0;
        if (div_done) begin
            result_d = {div_rem, div_quo};
            valid_d  = 1'b1;
        end else if (stg_vld_q) begin
            result_d = alu_res;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q <= 1'b0;
            stg_op_q  <= OP_ADD;
            stg_a_q   <= '0;
            stg_b_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_op_q  <= stg_op_d;
            stg_a_q   <= stg_a_d;
            stg_b_q   <= stg_b_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected results and arrival cycles, monitor checks on valid.
module tb_alu;
    localparam int W  = 4;
    localparam int RW = 2 * W;

    typedef struct {
        logic [RW-1:0] res;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [1:0]    operation;
    logic [W-1:0]  A, B;
    logic [RW-1:0] result;
    logic          valid;

    alu #(.inSize(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .operation (operation),
        .A         (A),
        .B         (B),
        .result    (result),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          sb[$];
    exp_t          mon_e;
    logic [RW-1:0] exp_last = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^RW; divide packs {rem, quo}.
    function automatic logic [RW-1:0] model(logic [1:0] op, int a, int b);
        int r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = (b == 0) ? (a * (1 << W) + (1 << W) - 1)
                                  : ((a % b) * (1 << W) + a / b);
        endcase
        return RW'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got result %0h with no pending op (cycle %0d)", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        en        = 1'b1;
        operation = op;
        A         = a;
        B         = b;
        exp_last  = model(op, int'(a), int'(b));
        sb.push_back('{res: exp_last, cyc: (op == 2'd3) ? cyc + W + 2 : cyc + 2});
        @(posedge clk); #1;
        if (op == 2'd3) begin
            repeat (W) begin
                en        = 1'($urandom_range(0, 1));
                operation = 2'($urandom);
                A         = W'($urandom);
                B         = W'($urandom);
                @(posedge clk); #1;
            end
            en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_and_hold();
        int t = 0;
        en = 1'b0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", 32'(result), 32'(exp_last));
        check("hold_valid", 32'(valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; operation = 2'd0; A = 4'd1; B = 4'd2;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_result", 32'(result), 32'd0);
            check("reset_valid", 32'(valid), 32'd0);
        end
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;

        issue(2'd0, 4'd1, 4'd2);
        issue(2'd0, 4'd15, 4'd15);
        issue(2'd2, 4'd7, 4'd4);
        issue(2'd2, 4'd15, 4'd15);
        issue(2'd1, 4'd5, 4'd3);
        issue(2'd1, 4'd3, 4'd5);
        issue(2'd3, 4'd13, 4'd4);
        issue(2'd3, 4'd9, 4'd0);
        issue(2'd3, 4'd15, 4'd1);
        issue(2'd0, 4'd0, 4'd0);
        drain_and_hold();

        repeat (150) issue(2'($urandom), W'($urandom), W'($urandom));
        drain_and_hold();

        // A divide aborted by reset must never complete and leaves result cleared.
        en = 1'b1; operation = 2'd3; A = 4'd13; B = 4'd4;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
